// File: rtl/multi_cycle_ctrl.sv
// Control-unit FSM for the multi-cycle CPU: sequences IF/ID/EXE/MEM/WB,
// decodes opcode plus ALU flags into datapath strobes, and counts retired instructions.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             mRD,
    output logic             mWR,
    output logic             DBDataSrc,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_R  = 4'd2,
        S_EXE_B  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_L   = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001, OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101, OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;

    state_t cur, nxt;
    logic   is_imm;
    logic   taken;

    assign state  = cur;
    assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ORI) || (opcode == OP_SLTI);
    assign taken  = ((opcode == OP_BEQ)  &&  zero) ||
                    ((opcode == OP_BNE)  && !zero) ||
                    ((opcode == OP_BLTZ) &&  sign);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        nxt       = cur;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        RegDst    = 2'b00;
        WrRegDSrc = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        PCSrc     = 2'b00;
        halted    = 1'b0;
        case (cur)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
                nxt      = S_ID;
            end
            S_ID: begin
                case (opcode)
                    OP_J: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                        nxt   = S_IF;
                    end
                    OP_JR: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                        nxt   = S_IF;
                    end
                    OP_JAL: begin
                        PCWre  = 1'b1;
                        PCSrc  = 2'b11;
                        RegWre = 1'b1;
                        nxt    = S_IF;
                    end
                    OP_BEQ, OP_BNE, OP_BLTZ:                 nxt = S_EXE_B;
                    OP_LW, OP_SW:                            nxt = S_EXE_LS;
                    OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
                    OP_ORI, OP_SLL, OP_SLT, OP_SLTI:         nxt = S_EXE_R;
                    default:                                 nxt = S_HALT;  // halt and illegal opcodes
                endcase
            end
            S_EXE_R: begin
                case (opcode)
                    OP_SUB:                 ALUOp = 3'b001;
                    OP_SLL:                 ALUOp = 3'b010;
                    OP_OR, OP_ORI:          ALUOp = 3'b011;
                    OP_AND:                 ALUOp = 3'b100;
                    OP_SLT, OP_SLTI:        ALUOp = 3'b101;
                    default:                ALUOp = 3'b000;
                endcase
                ALUSrcA = (opcode == OP_SLL);
                ALUSrcB = is_imm;
                ExtSel  = (opcode != OP_ORI);
                nxt     = S_WB_R;
            end
            S_EXE_B: begin
                ALUOp  = 3'b001;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = {1'b0, taken};
                nxt    = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                nxt     = S_MEM;
            end
            S_MEM: begin
                if (opcode == OP_SW) begin
                    mWR   = 1'b1;
                    PCWre = 1'b1;
                    nxt   = S_IF;
                end else begin
                    mRD = 1'b1;
                    nxt = S_WB_L;
                end
            end
            S_WB_R: begin
                RegWre    = 1'b1;
                RegDst    = is_imm ? 2'b01 : 2'b10;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                nxt       = S_IF;
            end
            S_WB_L: begin
                RegWre    = 1'b1;
                RegDst    = 2'b01;
                WrRegDSrc = 1'b1;
                DBDataSrc = 1'b1;
                PCWre     = 1'b1;
                nxt       = S_IF;
            end
            S_HALT: begin
                halted = 1'b1;
                nxt    = S_HALT;
            end
            default: nxt = S_IF;
        endcase

        // Reset must silence the fetch strobes that state IF would otherwise drive.
        if (!Reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            InsMemRW  = 1'b0;
            RegWre    = 1'b0;
            RegDst    = 2'b00;
            WrRegDSrc = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            ALUOp     = 3'b000;
            mRD       = 1'b0;
            mWR       = 1'b0;
            DBDataSrc = 1'b0;
            PCSrc     = 2'b00;
            halted    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cur         <= S_IF;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (PCWre)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Table-driven bench for multi_cycle_ctrl: per-cycle expected state, strobes and count,
// plus directed halt-freeze and mid-instruction reset sequences.
module tb_multi_cycle_ctrl;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [5:0]  opcode;
    logic        zero, sign;
    logic        PCWre, IRWre, InsMemRW, RegWre, WrRegDSrc, ALUSrcA, ALUSrcB, ExtSel;
    logic        mRD, mWR, DBDataSrc, halted;
    logic [1:0]  RegDst, PCSrc;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] instr_count;

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
        .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
        .PCSrc(PCSrc), .state(state), .halted(halted), .instr_count(instr_count)
    );

    always #5 CLK = ~CLK;

    // Packed view of all strobes: bit positions match the masks below.
    logic [18:0] ctrl;
    assign ctrl = {PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, ALUSrcA, ALUSrcB,
                   ExtSel, ALUOp, mRD, mWR, DBDataSrc, PCSrc, halted};

    localparam logic [18:0] F_PCW  = 19'(1) << 18, F_IRW = 19'(1) << 17, F_IMR = 19'(1) << 16;
    localparam logic [18:0] F_RW   = 19'(1) << 15, D_RT  = 19'(1) << 13, D_RD  = 19'(2) << 13;
    localparam logic [18:0] F_WRD  = 19'(1) << 12, F_SA  = 19'(1) << 11, F_SB  = 19'(1) << 10;
    localparam logic [18:0] F_EXT  = 19'(1) << 9;
    localparam logic [18:0] A_SUB  = 19'(1) << 6, A_SLL = 19'(2) << 6, A_OR = 19'(3) << 6;
    localparam logic [18:0] A_AND  = 19'(4) << 6, A_SLT = 19'(5) << 6;
    localparam logic [18:0] F_MRD  = 19'(1) << 5, F_MWR = 19'(1) << 4, F_DBS = 19'(1) << 3;
    localparam logic [18:0] P_BR   = 19'(1) << 1, P_RS  = 19'(2) << 1, P_J  = 19'(3) << 1;
    localparam logic [18:0] F_HLT  = 19'(1);
    localparam logic [18:0] FETCH  = F_IRW | F_IMR;
    localparam logic [18:0] NONE   = 19'(0);

    localparam logic [5:0] ADD = 6'b000000, ADDI = 6'b000010, ORI = 6'b010010, AND_ = 6'b010001;
    localparam logic [5:0] SLL = 6'b011000, SLTI = 6'b100111, SW = 6'b110000, LW = 6'b110001;
    localparam logic [5:0] BEQ = 6'b110100, BNE = 6'b110101, BLTZ = 6'b110110;
    localparam logic [5:0] J = 6'b111000, JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

    typedef struct {
        logic [5:0]  op;
        logic        z;
        logic        s;
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic row(input logic [5:0] op, input logic z, input logic s,
                       input logic [3:0] st, input logic [18:0] ctl, input logic [31:0] cnt);
        vec_t v;
        v.op = op; v.z = z; v.s = s; v.st = st; v.ctl = ctl; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        // One row per clock, continuing from reset release.
        row(ADD, 0, 0, 0, FETCH, 0);
        row(ADD, 0, 0, 1, NONE, 0);
        row(ADD, 0, 0, 2, F_EXT, 0);
        row(ADD, 0, 0, 6, F_RW | D_RD | F_WRD | F_PCW, 0);
        row(ADDI, 0, 0, 0, FETCH, 1);
        row(ADDI, 0, 0, 1, NONE, 1);
        row(ADDI, 1, 0, 2, F_SB | F_EXT, 1);
        row(ADDI, 0, 0, 6, F_RW | D_RT | F_WRD | F_PCW, 1);
        row(ORI, 0, 0, 0, FETCH, 2);
        row(ORI, 0, 0, 1, NONE, 2);
        row(ORI, 0, 0, 2, A_OR | F_SB, 2);
        row(ORI, 0, 0, 6, F_RW | D_RT | F_WRD | F_PCW, 2);
        row(SLL, 0, 0, 0, FETCH, 3);
        row(SLL, 0, 0, 1, NONE, 3);
        row(SLL, 0, 0, 2, A_SLL | F_SA | F_EXT, 3);
        row(SLL, 0, 0, 6, F_RW | D_RD | F_WRD | F_PCW, 3);
        row(SLTI, 0, 0, 0, FETCH, 4);
        row(SLTI, 0, 0, 1, NONE, 4);
        row(SLTI, 0, 1, 2, A_SLT | F_SB | F_EXT, 4);
        row(SLTI, 0, 0, 6, F_RW | D_RT | F_WRD | F_PCW, 4);
        row(LW, 0, 0, 0, FETCH, 5);
        row(LW, 0, 0, 1, NONE, 5);
        row(LW, 0, 0, 4, F_SB | F_EXT, 5);
        row(LW, 0, 0, 5, F_MRD, 5);
        row(LW, 0, 0, 7, F_RW | D_RT | F_WRD | F_DBS | F_PCW, 5);
        row(SW, 0, 0, 0, FETCH, 6);
        row(SW, 0, 0, 1, NONE, 6);
        row(SW, 0, 0, 4, F_SB | F_EXT, 6);
        row(SW, 0, 0, 5, F_MWR | F_PCW, 6);
        row(BEQ, 1, 0, 0, FETCH, 7);
        row(BEQ, 1, 0, 1, NONE, 7);
        row(BEQ, 1, 0, 3, A_SUB | F_EXT | F_PCW | P_BR, 7);
        row(BEQ, 0, 0, 0, FETCH, 8);
        row(BEQ, 0, 0, 1, NONE, 8);
        row(BEQ, 0, 0, 3, A_SUB | F_EXT | F_PCW, 8);
        row(BNE, 0, 0, 0, FETCH, 9);
        row(BNE, 0, 0, 1, NONE, 9);
        row(BNE, 0, 0, 3, A_SUB | F_EXT | F_PCW | P_BR, 9);
        row(BNE, 1, 0, 0, FETCH, 10);
        row(BNE, 1, 0, 1, NONE, 10);
        row(BNE, 1, 0, 3, A_SUB | F_EXT | F_PCW, 10);
        row(BLTZ, 0, 1, 0, FETCH, 11);
        row(BLTZ, 0, 1, 1, NONE, 11);
        row(BLTZ, 0, 1, 3, A_SUB | F_EXT | F_PCW | P_BR, 11);
        row(BLTZ, 1, 0, 0, FETCH, 12);
        row(BLTZ, 1, 0, 1, NONE, 12);
        row(BLTZ, 1, 0, 3, A_SUB | F_EXT | F_PCW, 12);
        row(J, 0, 0, 0, FETCH, 13);
        row(J, 0, 0, 1, F_PCW | P_J, 13);
        row(JR, 0, 0, 0, FETCH, 14);
        row(JR, 0, 0, 1, F_PCW | P_RS, 14);
        row(JAL, 0, 0, 0, FETCH, 15);
        row(JAL, 0, 0, 1, F_PCW | P_J | F_RW, 15);
        row(AND_, 0, 0, 0, FETCH, 16);
        row(AND_, 0, 0, 1, NONE, 16);
        row(AND_, 0, 0, 2, A_AND | F_EXT, 16);
        row(AND_, 0, 0, 6, F_RW | D_RD | F_WRD | F_PCW, 16);
        row(HALT, 0, 0, 0, FETCH, 17);
        row(HALT, 0, 0, 1, NONE, 17);
        row(HALT, 0, 0, 8, F_HLT, 17);
        row(HALT, 0, 0, 8, F_HLT, 17);

        Reset = 1'b0; opcode = ADD; zero = 1'b0; sign = 1'b0;
        #1;
        check("reset_ctrl", 64'(ctrl), 64'(NONE));
        check("reset_state", 64'(state), 64'd0);
        check("reset_cnt", 64'(instr_count), 64'd0);
        @(negedge CLK);
        Reset = 1'b1;

        foreach (vecs[i]) begin
            opcode = vecs[i].op; zero = vecs[i].z; sign = vecs[i].s;
            #1;
            check($sformatf("row%0d_state", i), 64'(state), 64'(vecs[i].st));
            check($sformatf("row%0d_ctrl", i), 64'(ctrl), 64'(vecs[i].ctl));
            check($sformatf("row%0d_cnt", i), 64'(instr_count), 64'(vecs[i].cnt));
            @(negedge CLK);
        end

        // HALT holds and the retired count stays frozen.
        repeat (10) @(negedge CLK);
        #1;
        check("halt_hold_state", 64'(state), 64'd8);
        check("halt_hold_ctrl", 64'(ctrl), 64'(F_HLT));
        check("halt_hold_cnt", 64'(instr_count), 64'd17);

        // Illegal opcode after a fresh reset also halts.
        Reset = 1'b0; opcode = 6'b101010;
        #1;
        check("rst2_ctrl", 64'(ctrl), 64'(NONE));
        check("rst2_cnt", 64'(instr_count), 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        check("illegal_state", 64'(state), 64'd8);
        check("illegal_ctrl", 64'(ctrl), 64'(F_HLT));
        repeat (10) @(negedge CLK);
        #1;
        check("illegal_cnt_frozen", 64'(instr_count), 64'd0);

        // Reset asserted in MEM of lw aborts the instruction asynchronously.
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1; opcode = ADD;
        repeat (4) @(negedge CLK);
        opcode = LW;
        repeat (3) @(negedge CLK);
        #1;
        check("lw_mem_state", 64'(state), 64'd5);
        check("lw_mem_ctrl", 64'(ctrl), 64'(F_MRD));
        check("lw_mem_cnt", 64'(instr_count), 64'd1);
        #2;
        Reset = 1'b0;
        #1;
        check("abort_ctrl", 64'(ctrl), 64'(NONE));
        check("abort_state", 64'(state), 64'd0);
        check("abort_cnt", 64'(instr_count), 64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check("restart_state", 64'(state), 64'd1);
        check("restart_ctrl", 64'(ctrl), 64'(NONE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Control-unit FSM for the multi-cycle CPU; sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives the write enables and mux selects for PC, IR, register file, ALU, data memory and the inter-stage registers (ADR/BDR/ALUoutDR/DBDR).
- Decodes the 6-bit opcode plus the ALU zero/sign flags.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- opcode  input  6  IR[31:26], valid from ID onward.
- zero  input  1  ALU result == 0.
- sign  input  1  ALU result bit 31.
- PCWre  output  1  PC load enable (commit strobe).
- IRWre  output  1  IR load enable.
- InsMemRW  output  1  instruction-memory read.
- RegWre  output  1  register-file write.
- RegDst  output  2  00 = $31, 01 = rt, 10 = rd.
- WrRegDSrc  output  1  0 = PC+4, 1 = DB bus.
- ALUSrcA  output  1  0 = ADR (rs), 1 = shamt.
- ALUSrcB  output  1  0 = BDR (rt), 1 = extended imm.
- ExtSel  output  1  0 = zero-extend, 1 = sign-extend.
- ALUOp  output  3  000 add, 001 sub, 010 B<<A, 011 or, 100 and, 101 signed A<B.
- mRD  output  1  data-memory read.
- mWR  output  1  data-memory write.
- DBDataSrc  output  1  0 = ALUoutDR, 1 = DBDR.
- PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 rs, 11 {PC[31:28], addr, 00}.
- state  output  4  current state, for debug.
- halted  output  1  FSM is in HALT.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
Opcodes:
- add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010.
- sll 011000, slt 100110, slti 100111.
- sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110.
- j 111000, jr 111001, jal 111010, halt 111111.
- Any other opcode is treated as halt.

State register:
- 4 bits, async clear to IF when Reset=0.
- Encoding: IF=0, ID=1, EXE_R=2, EXE_B=3, EXE_LS=4, MEM=5, WB_R=6, WB_L=7, HALT=8.

Transitions (one state per clock):
- IF -> ID.
- ID -> IF for j, jr, jal.
- ID -> HALT for halt or an illegal opcode.
- ID -> EXE_B for beq, bne, bltz.
- ID -> EXE_LS for lw, sw.
- ID -> EXE_R otherwise.
- EXE_R -> WB_R.
- EXE_B -> IF.
- EXE_LS -> MEM.
- MEM -> IF for sw; MEM -> WB_L for lw.
- WB_R -> IF; WB_L -> IF.
- HALT -> HALT until Reset.

Latency in cycles: j/jr/jal 2, branch 3, R-type/imm 4, sw 4, lw 5.

Outputs:
- All outputs are combinational from state and opcode (plus zero/sign in EXE_B).
- Every signal not listed below is 0.
- While Reset=0, all outputs are 0 and instr_count is 0.
- IF: InsMemRW=1, IRWre=1.
- ID, j: PCWre=1, PCSrc=11.
- ID, jr: PCWre=1, PCSrc=10.
- ID, jal: PCWre=1, PCSrc=11, RegWre=1, RegDst=00, WrRegDSrc=0.
- EXE_R: ALUOp per opcode. ALUSrcA=1 for sll. ALUSrcB=1 for addi/ori/slti. ExtSel=0 only for ori.
- EXE_B: ALUOp=001, ExtSel=1, PCWre=1.
  - PCSrc=01 if taken, else 00.
  - Taken: beq when zero=1, bne when zero=0, bltz when sign=1.
- EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
- MEM, sw: mWR=1, PCWre=1, PCSrc=00.
- MEM, lw: mRD=1.
- WB_R: RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
  - RegDst=01 for addi/ori/slti, 10 otherwise.
- WB_L: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, PCSrc=00.
- HALT: halted=1; PCWre, RegWre and mWR are held at 0.

instr_count:
- Increments on every rising edge where PCWre=1; wraps modulo 2^CNT_W.
- Async-cleared by Reset.

Reset mid-instruction:
- Aborts immediately: state goes to IF and no write strobes are asserted.
- Fetch restarts on the first edge after Reset returns high.

Test Plan:
- Release Reset, opcode=000000 (add), 4 cycles -> state sequence 0,1,2,6,0. PCWre=1 and RegWre=1 with RegDst=10 only in WB_R. instr_count=1.
- lw (110001) -> states 0,1,4,5,7,0. mRD=1 in MEM. In WB_L: DBDataSrc=1, RegDst=01, RegWre=1. 5 cycles; sw gives 0,1,4,5,0 with mWR=1 in MEM only.
- Branches in EXE_B:
  - beq with zero=1 -> PCSrc=01.
  - beq with zero=0 -> PCSrc=00.
  - bne with zero=0 -> PCSrc=01.
  - bltz with sign=1 -> PCSrc=01.
  - Each takes 3 cycles.
- jal (111010) -> in ID: PCSrc=11, RegDst=00, WrRegDSrc=0, RegWre=1, PCWre=1; next state IF. jr -> PCSrc=10.
- Opcode 111111, then opcode 101010 after a reset -> both reach HALT (8) with halted=1. instr_count is frozen across 10 further clocks.
- Assert Reset=0 in MEM of lw -> all outputs 0 asynchronously, state=0, instr_count=0. After release, the next edge gives state ID.
